reg_wb_arbiter: RTL and testbench
=================================

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 STARVE_MAX, 4, consecutive lost-arbitration cycles of the load FIFO head before the ALU is forced to stall (2..15).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 alu_valid  input  1  ALU writeback request, this cycle only.
REQ-006 alu_reg  input  5  ALU destination register.
REQ-007 alu_data  input  32  ALU result.
REQ-008 alu_stall  output  1  forces the ALU to withhold alu_valid this cycle.
REQ-009 ld_valid  input  1  load writeback request.
REQ-010 ld_ready  output  1  load request accepted when ld_valid and ld_ready are both high.
REQ-011 ld_reg  input  5  load destination register.
REQ-012 ld_data  input  32  load data.
REQ-013 reg_write  output  1  register-file write enable, registered.
REQ-014 WB_reg  output  5  register-file write address, registered.
REQ-015 WB_result  output  32  register-file write data, registered.
REQ-016 pending  output  32  bit i high while any queued load targets register i.
REQ-017 err  output  1  sticky flag for an ALU request received during alu_stall.

Function
REQ-018 Loads SHALL be buffered in a 2-entry FIFO; ld_ready SHALL equal not-full.
REQ-019 A load with ld_reg=0 SHALL be accepted and discarded, not enqueued.
REQ-020 An ALU request with alu_reg=0 SHALL be ignored; it consumes no grant.
REQ-021 Grant each cycle: if alu_stall=0 and an ALU request is valid and nonzero, the ALU wins; otherwise a non-empty FIFO pops its head.
REQ-022 The grant SHALL register into reg_write/WB_reg/WB_result on the next edge; no grant means reg_write=0, with WB_reg/WB_result held.
REQ-023 Latency: ALU request to reg_write is 1 cycle; load acceptance to reg_write is at least 2 cycles, with no bypass past the FIFO.
REQ-024 Push and pop in the same cycle SHALL be allowed whenever the FIFO is not full; the count is unchanged.
REQ-025 Starvation counter:
  - increments each cycle the FIFO is non-empty and the ALU wins;
  - clears on any FIFO pop or when the FIFO is empty;
  - saturates at STARVE_MAX.
REQ-026 alu_stall SHALL be combinational and high while counter == STARVE_MAX and the FIFO is non-empty; in that cycle the FIFO head SHALL be granted.
REQ-027 An alu_valid with a nonzero reg received while alu_stall=1 SHALL be dropped and SHALL set err until reset.
REQ-028 pending SHALL be combinational from valid FIFO entries; duplicate targets are OR-ed.
REQ-029 Order between ALU and load writes to the same register is not preserved; upstream SHALL use pending to avoid WAW.

Reset
REQ-030 Reset SHALL asynchronously:
  - empty the FIFO;
  - clear the counter and err;
  - drive reg_write=0, WB_reg=0, WB_result=0, pending=0, alu_stall=0.
REQ-031 ld_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-032 Reset mid-operation SHALL discard queued loads without issuing a write.

Structure
REQ-033 Package reg_wb_pkg SHALL hold REG_ADDR_W=5, DATA_W=32, FIFO_DEPTH=2 and the STARVE_MAX default.
REQ-034 Sub-module wb_fifo SHALL implement the 2-entry FIFO with a per-entry destination output for pending; all arbitration logic stays in reg_wb_arbiter.

Verification
REQ-035 Single ALU: alu_valid, reg 3, data 0x0000_00AA -> next cycle reg_write=1, WB_reg=3, WB_result=0xAA.
REQ-036 Load while idle: load reg 7, data 0x1234_5678 -> pending[7]=1 for one cycle, then reg_write with WB_reg=7, two edges after acceptance.
REQ-037 Full FIFO: two loads (regs 4, 5) under continuous ALU traffic -> ld_ready=0, pending=0x30.
REQ-038 Starvation, STARVE_MAX=4, continuous ALU traffic:
  - alu_stall rises on the 5th cycle and reg 4 is written;
  - an ALU request offered in that cycle sets err=1.
REQ-039 Register zero: ALU reg 0 and load reg 0 -> no reg_write, pending stays 0, ld_ready stays 1.
REQ-040 Reset pulse with two queued loads -> outputs zero at once, no later write to regs 4/5, ld_ready=1 after release.

Source files
------------

// File: rtl/reg_wb_pkg.sv
// Shared widths, defaults and writeback payload type for the register writeback arbiter.
package reg_wb_pkg;

    localparam int unsigned REG_ADDR_W     = 5;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned FIFO_DEPTH     = 2;
    localparam int unsigned STARVE_MAX_DEF = 4;
    localparam int unsigned STARVE_CNT_W   = 4;
    localparam int unsigned NUM_REGS       = 1 << REG_ADDR_W;

    // One queued register-file write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] dest;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    // One-hot decode of a destination register index.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
        reg_onehot = NUM_REGS'(1) << r;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small load-writeback FIFO; exposes per-entry destinations so the top can build the pending mask.
module wb_fifo
    import reg_wb_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              push,
    input  wb_entry_t                         push_entry,
    input  logic                              pop,
    output logic                              full,
    output logic                              empty,
    output wb_entry_t                         head,
    output logic [FIFO_DEPTH-1:0]             entry_valid,
    output logic [FIFO_DEPTH*REG_ADDR_W-1:0]  entry_dest
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    wb_entry_t        mem [FIFO_DEPTH];
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointer and occupancy tracking; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_ok) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        entry_dest  = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_valid[i] = (CNT_W'(PTR_W'(PTR_W'(i) - rd_ptr)) < count);
            entry_dest[i*REG_ADDR_W +: REG_ADDR_W] = mem[i].dest;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Arbitrates one register-file write port between single-cycle ALU results and queued loads.
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0]     alu_data,
    output logic                  alu_stall,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_reg,
    input  logic [DATA_W-1:0]     ld_data,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] WB_reg,
    output logic [DATA_W-1:0]     WB_result,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  err
);

    logic                             alu_req;
    logic                             alu_grant;
    logic                             ld_push;
    logic                             fifo_pop;
    logic                             fifo_full;
    logic                             fifo_empty;
    wb_entry_t                        fifo_head;
    wb_entry_t                        ld_entry;
    logic [FIFO_DEPTH-1:0]            entry_valid;
    logic [FIFO_DEPTH*REG_ADDR_W-1:0] entry_dest;
    logic [STARVE_CNT_W-1:0]          starve_cnt;
    logic [STARVE_CNT_W-1:0]          starve_cnt_nxt;
    logic                             starve_hit;

    // Writes to register zero are architecturally meaningless and never compete for the port.
    assign alu_req    = alu_valid && (alu_reg != '0);
    assign ld_ready   = !fifo_full;
    assign ld_push    = ld_valid && ld_ready && (ld_reg != '0);
    assign ld_entry   = '{dest: ld_reg, data: ld_data};

    assign starve_hit = (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
    assign alu_stall  = !fifo_empty && starve_hit;
    assign alu_grant  = alu_req && !alu_stall;
    assign fifo_pop   = !alu_grant && !fifo_empty;

    wb_fifo u_wb_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (ld_push),
        .push_entry  (ld_entry),
        .pop         (fifo_pop),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .head        (fifo_head),
        .entry_valid (entry_valid),
        .entry_dest  (entry_dest)
    );

    // Count cycles the load head loses to the ALU; any pop or empty queue restarts the count.
    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (fifo_empty || fifo_pop) begin
            starve_cnt_nxt = '0;
        end else if (alu_grant && !starve_hit) begin
            starve_cnt_nxt = starve_cnt + STARVE_CNT_W'(1);
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_cnt_nxt;
        end
    end

    // Register the granted write; address and data hold when nothing is granted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            reg_write <= 1'b0;
            WB_reg    <= '0;
            WB_result <= '0;
        end else begin
            reg_write <= alu_grant || fifo_pop;
            if (alu_grant) begin
                WB_reg    <= alu_reg;
                WB_result <= alu_data;
            end else if (fifo_pop) begin
                WB_reg    <= fifo_head.dest;
                WB_result <= fifo_head.data;
            end
        end
    end

    // Sticky error for an ALU result that arrived while it was told to stall.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if (alu_req && alu_stall) begin
            err <= 1'b1;
        end
    end

    // Mask of registers with an outstanding queued load.
    always_comb begin
        pending = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i]) begin
                pending = pending | reg_onehot(entry_dest[i*REG_ADDR_W +: REG_ADDR_W]);
            end
        end
    end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with hand-computed expectations.
module tb_reg_wb_arbiter;

    logic        clock;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_reg;
    logic [31:0] ld_data;
    logic        reg_write;
    logic [4:0]  WB_reg;
    logic [31:0] WB_result;
    logic [31:0] pending;
    logic        err;

    int n_vec;
    int n_err;

    reg_wb_arbiter #(.STARVE_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_reg   (alu_reg),
        .alu_data  (alu_data),
        .alu_stall (alu_stall),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_reg    (ld_reg),
        .ld_data   (ld_data),
        .reg_write (reg_write),
        .WB_reg    (WB_reg),
        .WB_result (WB_result),
        .pending   (pending),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_alu(input logic v, input logic [4:0] r, input logic [31:0] d);
        alu_valid = v;
        alu_reg   = r;
        alu_data  = d;
    endtask

    task automatic drive_ld(input logic v, input logic [4:0] r, input logic [31:0] d);
        ld_valid = v;
        ld_reg   = r;
        ld_data  = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_vec({tag, "_reg_write"}, 32'(reg_write), 32'h0);
        check_vec({tag, "_WB_reg"},    32'(WB_reg),    32'h0);
        check_vec({tag, "_WB_result"}, WB_result,      32'h0);
        check_vec({tag, "_pending"},   pending,        32'h0);
        check_vec({tag, "_alu_stall"}, 32'(alu_stall), 32'h0);
        check_vec({tag, "_err"},       32'(err),       32'h0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        reset = 1'b1;
        #22;
        check_idle_outputs("rst");
        tick();
        reset = 1'b0;
        check_vec("rst_ld_ready", 32'(ld_ready), 32'h1);

        // Single ALU write: visible one edge later.
        drive_alu(1'b1, 5'd3, 32'h0000_00AA);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check_vec("alu_reg_write", 32'(reg_write), 32'h1);
        check_vec("alu_WB_reg",    32'(WB_reg),    32'd3);
        check_vec("alu_WB_result", WB_result,      32'hAA);
        tick();
        check_vec("idle_reg_write", 32'(reg_write), 32'h0);
        check_vec("idle_WB_hold",   32'(WB_reg),    32'd3);

        // Load while idle: pending for one cycle, write two edges after acceptance.
        drive_ld(1'b1, 5'd7, 32'h1234_5678);
        check_vec("ld_ready_idle", 32'(ld_ready), 32'h1);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        check_vec("ld_pending7",   pending,        32'h0000_0080);
        check_vec("ld_no_bypass",  32'(reg_write), 32'h0);
        tick();
        check_vec("ld_reg_write",  32'(reg_write), 32'h1);
        check_vec("ld_WB_reg",     32'(WB_reg),    32'd7);
        check_vec("ld_WB_result",  WB_result,      32'h1234_5678);
        check_vec("ld_pending_clr", pending,       32'h0);
        tick();
        check_vec("ld_done",       32'(reg_write), 32'h0);

        // Register zero from both sources is ignored.
        drive_alu(1'b1, 5'd0, 32'h55);
        drive_ld(1'b1, 5'd0, 32'h66);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        check_vec("r0_reg_write", 32'(reg_write), 32'h0);
        check_vec("r0_pending",   pending,        32'h0);
        check_vec("r0_ld_ready",  32'(ld_ready),  32'h1);
        tick();
        check_vec("r0_drain",     32'(reg_write), 32'h0);

        // Fill the FIFO under continuous ALU traffic, then starve until the stall forces a pop.
        drive_alu(1'b1, 5'd10, 32'h10);
        drive_ld(1'b1, 5'd4, 32'h44);
        tick();
        check_vec("fill_WB_reg10", 32'(WB_reg),  32'd10);
        check_vec("fill_pend1",    pending,      32'h10);
        drive_alu(1'b1, 5'd11, 32'h11);
        drive_ld(1'b1, 5'd5, 32'h55);
        check_vec("fill_ready2",   32'(ld_ready),  32'h1);
        check_vec("starve_c1",     32'(alu_stall), 32'h0);
        tick();
        drive_ld(1'b0, 5'd0, 32'h0);
        check_vec("full_ld_ready", 32'(ld_ready), 32'h0);
        check_vec("full_pending",  pending,       32'h30);
        check_vec("fill_WB_reg11", 32'(WB_reg),   32'd11);
        for (int k = 0; k < 3; k++) begin
            drive_alu(1'b1, 5'(12 + k), 32'(32'h100 + k));
            check_vec("starve_nostall", 32'(alu_stall), 32'h0);
            tick();
            check_vec("starve_alu_wins", 32'(WB_reg), 32'(12 + k));
        end
        check_vec("stall_5th",     32'(alu_stall), 32'h1);
        check_vec("stall_no_err",  32'(err),       32'h0);
        drive_alu(1'b1, 5'd15, 32'hF);
        tick();
        drive_alu(1'b0, 5'd0, 32'h0);
        check_vec("stall_reg_write", 32'(reg_write), 32'h1);
        check_vec("stall_WB_reg4",   32'(WB_reg),    32'd4);
        check_vec("stall_WB_res",    WB_result,      32'h44);
        check_vec("stall_err",       32'(err),       32'h1);
        check_vec("stall_pending",   pending,        32'h20);
        check_vec("stall_released",  32'(alu_stall), 32'h0);
        check_vec("stall_ready",     32'(ld_ready),  32'h1);
        tick();
        check_vec("drain_WB_reg5",   32'(WB_reg),    32'd5);
        check_vec("drain_WB_res",    WB_result,      32'h55);
        check_vec("drain_pending",   pending,        32'h0);
        check_vec("err_sticky",      32'(err),       32'h1);
        tick();
        check_vec("drain_idle",      32'(reg_write), 32'h0);

        // Reset with two queued loads discards them.
        drive_alu(1'b1, 5'd20, 32'h20);
        drive_ld(1'b1, 5'd4, 32'h44);
        tick();
        drive_alu(1'b1, 5'd21, 32'h21);
        drive_ld(1'b1, 5'd5, 32'h55);
        tick();
        check_vec("rq_pending", pending,       32'h30);
        check_vec("rq_full",    32'(ld_ready), 32'h0);
        drive_alu(1'b0, 5'd0, 32'h0);
        drive_ld(1'b0, 5'd0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_idle_outputs("rst_mid");
        tick();
        tick();
        reset = 1'b0;
        check_vec("rst_mid_ready", 32'(ld_ready), 32'h1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_vec("rst_no_write", 32'(reg_write), 32'h0);
            check_vec("rst_no_pend",  pending,        32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
